// File: rtl/sseg_pkg.sv
// sseg_pkg: shared types and constants for the seven-segment scan path
package sseg_pkg;
  localparam int DIGITS = 4;
  typedef logic [1:0] digit_sel_t;
  typedef enum logic {IDLE, PEND} scan_state_t;
  localparam logic HEX = 1'b1;
  localparam logic DEC = 1'b0;
endpackage

// File: rtl/sseg_scan_ctrl_tick_gen.sv
// tick_gen: free-running prescaler, cleared while disabled, pulses on its last count
//  clk, rst_n : clock, async active-low reset
//  en         : count enable; 0 clears the count on the next edge
//  tick       : high in the cycle the count is all-ones while enabled
module tick_gen #(
  parameter int W = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  logic [W-1:0] count;
  assign tick = en && &count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= en ? count + 1'b1 : '0;
endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: digit scan sequencer with frame-aligned commit of display updates
//  clk, rst_n                      : clock, async active-low reset
//  enable                          : 1 = scanning, 0 = halted and blanked
//  upd_valid/upd_ready             : handshake for a new display value
//  upd_data/upd_hex_dec/upd_sign   : offered value, format, minus sign
//  digit_sel                       : digit being driven (0 = rightmost)
//  data/hex_dec/sign               : committed value, format, sign
//  blank                           : turn all anodes off
//  frame_tick                      : pulse when digit_sel has just wrapped to 0
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int DIV_BITS = 17,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [DATA_W-1:0] upd_data,
  input  logic              upd_hex_dec,
  input  logic              upd_sign,
  output logic [1:0]        digit_sel,
  output logic [DATA_W-1:0] data,
  output logic              hex_dec,
  output logic              sign,
  output logic              blank,
  output logic              frame_tick
);
  logic digit_tick, frame_end, p_hex, p_sign;
  logic [DATA_W-1:0] p_data;
  scan_state_t state;
  tick_gen #(.W(DIV_BITS)) u_tick (.clk(clk), .rst_n(rst_n), .en(enable), .tick(digit_tick));
  assign frame_end = digit_tick && digit_sel == digit_sel_t'(DIGITS - 1);
  assign upd_ready = state == IDLE;
  // Commit shares the 3->0 edge with frame_tick; a halted scan commits at once so nothing waits forever.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      digit_sel  <= '0;
      data       <= '0;
      hex_dec    <= HEX;
      sign       <= 1'b0;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
      p_data     <= '0;
      p_hex      <= HEX;
      p_sign     <= 1'b0;
    end else begin
      digit_sel  <= !enable ? '0 : digit_tick ? digit_sel + 1'b1 : digit_sel;
      frame_tick <= frame_end;
      blank      <= ~enable;
      if (state == IDLE) begin
        if (upd_valid) begin
          p_data <= upd_data;
          p_hex  <= upd_hex_dec;
          p_sign <= upd_sign;
          state  <= PEND;
        end
      end else if (frame_end || !enable) begin
        data    <= p_data;
        hex_dec <= p_hex;
        sign    <= p_sign;
        state   <= IDLE;
      end
    end
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: randomized and directed checks against a cycle-count reference model
module tb_sseg_scan_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, upd_valid = 1'b0, upd_hex_dec = 1'b0, upd_sign = 1'b0;
  logic [15:0] upd_data = '0;
  logic upd_ready, hex_dec, sign, blank, frame_tick;
  logic [1:0] digit_sel;
  logic [15:0] data;
  int n_cmp = 0, n_bad = 0;
  int k;
  logic m_pend, m_ph, m_ps, m_hex, m_sign, m_blank, m_ft, mon = 1'b0, seen_aaaa = 1'b0;
  logic [15:0] m_pd, m_data;
  int cnt;
  logic fe;

  sseg_scan_ctrl #(.DIV_BITS(2), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_data(upd_data), .upd_hex_dec(upd_hex_dec), .upd_sign(upd_sign), .digit_sel(digit_sel),
    .data(data), .hex_dec(hex_dec), .sign(sign), .blank(blank), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // k = enabled edges since scan (re)start; digit = k/4 mod 4, frame every 16 enabled edges.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k = 0; m_pend = 0; m_pd = '0; m_ph = 1; m_ps = 0;
      m_data = '0; m_hex = 1; m_sign = 0; m_blank = 1; m_ft = 0;
    end else begin
      fe = enable && ((k + 1) % 16 == 0);
      if (!m_pend) begin
        if (upd_valid) begin m_pend = 1; m_pd = upd_data; m_ph = upd_hex_dec; m_ps = upd_sign; end
      end else if (fe || !enable) begin
        m_pend = 0; m_data = m_pd; m_hex = m_ph; m_sign = m_ps;
      end
      m_ft = fe;
      m_blank = !enable;
      k = enable ? k + 1 : 0;
    end

  task automatic check_all();
    chk("digit_sel", 32'(digit_sel), 32'((k / 4) % 4));
    chk("frame_tick", 32'(frame_tick), 32'(m_ft));
    chk("blank", 32'(blank), 32'(m_blank));
    chk("upd_ready", 32'(upd_ready), 32'(!m_pend));
    chk("data", 32'(data), 32'(m_data));
    chk("hex_dec", 32'(hex_dec), 32'(m_hex));
    chk("sign", 32'(sign), 32'(m_sign));
  endtask

  always @(negedge clk) if (mon) begin
    check_all();
    if (data == 16'hAAAA) seen_aaaa = 1'b1;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic offer(input logic [15:0] d, input logic h, input logic s);
    upd_valid = 1'b1; upd_data = d; upd_hex_dec = h; upd_sign = s;
  endtask

  initial begin
    mon = 1'b1;
    repeat (3) step();
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_hex", 32'(hex_dec), 32'h1);
    chk("rst_blank", 32'(blank), 32'h1);
    rst_n = 1'b1; enable = 1'b1;
    step();
    chk("blank_after_en", 32'(blank), 32'h0);
    repeat (40) step();
    cnt = 0;
    while (digit_sel != 2'd1 && cnt < 40) begin step(); cnt++; end
    chk("wait_digit1", 32'(cnt < 40), 32'h1);
    offer(16'h1234, 1'b1, 1'b1);
    step();
    upd_valid = 1'b0;
    chk("busy_after_offer", 32'(upd_ready), 32'h0);
    cnt = 0;
    while (!frame_tick && cnt < 20) begin
      chk("hold_old", 32'(data != 16'h1234), 32'h1);
      step(); cnt++;
    end
    chk("commit_1234", 32'(data), 32'h1234);
    chk("commit_sign", 32'(sign), 32'h1);
    chk("ready_after_commit", 32'(upd_ready), 32'h1);
    cnt = 0;
    while (!((k + 1) % 16 == 0) && cnt < 20) begin step(); cnt++; end
    offer(16'hBEEF, 1'b0, 1'b0);
    step();
    offer(16'h5555, 1'b1, 1'b0);
    chk("beef_not_same_edge", 32'(data), 32'h1234);
    repeat (15) step();
    chk("beef_not_early", 32'(data), 32'h1234);
    chk("second_not_taken", 32'(upd_ready), 32'h0);
    step();
    chk("beef_commit", 32'(data), 32'hBEEF);
    step();
    upd_valid = 1'b0;
    cnt = 0;
    while (!upd_ready && cnt < 40) begin step(); cnt++; end
    offer(16'h0042, 1'b0, 1'b1);
    step();
    upd_valid = 1'b0; enable = 1'b0;
    step();
    chk("halt_commit", 32'(data), 32'h0042);
    chk("halt_digit", 32'(digit_sel), 32'h0);
    chk("halt_blank", 32'(blank), 32'h1);
    chk("halt_ready", 32'(upd_ready), 32'h1);
    enable = 1'b1;
    cnt = 0;
    do begin step(); cnt++; end while (!frame_tick && cnt < 40);
    chk("reenable_frame", 32'(cnt), 32'd16);
    offer(16'hAAAA, 1'b1, 1'b0);
    step();
    upd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_data", 32'(data), 32'h0);
    chk("async_ready", 32'(upd_ready), 32'h1);
    chk("async_blank", 32'(blank), 32'h1);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (40) step();
    chk("no_aaaa", 32'(seen_aaaa), 32'h0);
    repeat (2000) begin
      enable = ($urandom_range(19) != 0);
      upd_valid = $urandom_range(1);
      upd_data = 16'($urandom);
      upd_hex_dec = $urandom_range(1);
      upd_sign = $urandom_range(1);
      step();
    end
    mon = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
